// File: rtl/env_amp_dsm_if.sv
// Sample bus between the envelope stage and its neighbours: PCM/envelope in,
// enveloped sample, peak and PDM bitstream out.
interface env_amp_dsm_if #(
  parameter int PCM_W = 16,
  parameter int ENV_W = 16
);
  logic signed [PCM_W-1:0] pcm_in;
  logic                    pcm_valid;
  logic [ENV_W-1:0]        env;
  logic [3:0]              vol_shift;
  logic                    mute;
  logic                    peak_clr;
  logic signed [PCM_W-1:0] amp_pcm;
  logic                    amp_valid;
  logic [PCM_W-1:0]        peak_abs;
  logic                    pdm_out;

  modport master (
    output pcm_in, pcm_valid, env, vol_shift, mute, peak_clr,
    input  amp_pcm, amp_valid, peak_abs, pdm_out
  );

  modport slave (
    input  pcm_in, pcm_valid, env, vol_shift, mute, peak_clr,
    output amp_pcm, amp_valid, peak_abs, pdm_out
  );
endinterface

// File: rtl/env_amp_dsm.sv
// Envelope multiply, mute/volume shift, peak tracker and first-order PDM output.
// ENV_AMP_DSM_EN: when defined the delta-sigma accumulator is built, else pdm_out is 0.
module env_amp_dsm #(
  parameter int PCM_W = 16,
  parameter int ENV_W = 16
) (
  input logic          clk,
  input logic          reset_n,
  env_amp_dsm_if.slave bus
);
  localparam int STAGES = 2;
  localparam logic [PCM_W-1:0] PCM_MIN  = {1'b1, {(PCM_W-1){1'b0}}};
  localparam logic [PCM_W-1:0] PCM_MAXP = {1'b0, {(PCM_W-1){1'b1}}};

  typedef struct packed {
    logic signed [PCM_W-1:0] pcm;
    logic [ENV_W-1:0]        env;
  } s1_t;

  s1_t                     r_s1;
  logic signed [PCM_W:0]   r_q;
  logic [STAGES:0]         r_vld_pipe;
  logic signed [PCM_W-1:0] r_amp;
  logic [PCM_W-1:0]        r_peak;

  logic signed [PCM_W+ENV_W:0] w_p;
  logic signed [PCM_W:0]       w_sh;
  logic signed [PCM_W-1:0]     w_r;
  logic [PCM_W-1:0]            w_abs;
  logic [PCM_W-1:0]            w_peak_nxt;
  logic                        w_unused;

  // Envelope is zero-extended so the product stays signed; dropping the low
  // ENV_W bits of a two's-complement product is a floor divide.
  assign w_p  = r_s1.pcm * $signed({1'b0, r_s1.env});
  assign w_sh = r_q >>> bus.vol_shift;
  assign w_r  = bus.mute ? '0 : w_sh[PCM_W-1:0];
  assign w_unused = ^{w_p[ENV_W-1:0], w_sh[PCM_W]};

  always_comb begin
    w_abs = w_r;
    if (w_r[PCM_W-1])
      w_abs = (w_r == PCM_MIN) ? PCM_MAXP : PCM_W'(-w_r);
  end

  // A sample loaded on the same edge as a clear wins over the clear.
  always_comb begin
    w_peak_nxt = r_peak;
    if (r_vld_pipe[1])
      w_peak_nxt = (bus.peak_clr || (w_abs > r_peak)) ? w_abs : r_peak;
    else if (bus.peak_clr)
      w_peak_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1       <= '0;
      r_q        <= '0;
      r_vld_pipe <= '0;
      r_amp      <= '0;
      r_peak     <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], bus.pcm_valid};
      if (bus.pcm_valid) begin
        r_s1.pcm <= bus.pcm_in;
        r_s1.env <= bus.env;
      end
      if (r_vld_pipe[0]) r_q   <= w_p[ENV_W +: PCM_W+1];
      if (r_vld_pipe[1]) r_amp <= w_r;
      r_peak <= w_peak_nxt;
    end
  end

  assign bus.amp_pcm   = r_amp;
  assign bus.amp_valid = r_vld_pipe[STAGES];
  assign bus.peak_abs  = r_peak;

`ifdef ENV_AMP_DSM_EN
  logic [PCM_W-1:0] r_acc;
  logic             r_pdm;
  logic [PCM_W:0]   w_s;

  // Offset-binary input; the accumulator carry is the output pulse.
  assign w_s = {1'b0, r_acc} + {1'b0, (r_amp ^ PCM_MIN)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_pdm <= 1'b0;
    end else begin
      r_acc <= w_s[PCM_W-1:0];
      r_pdm <= w_s[PCM_W];
    end
  end

  assign bus.pdm_out = r_pdm;
`else
  assign bus.pdm_out = 1'b0;
`endif
endmodule

// File: tb/tb_env_amp_dsm.sv
// Self-checking bench for env_amp_dsm: vector table plus hand sequences,
// with an output scoreboard fed at stimulus time.
module tb_env_amp_dsm;
  logic clk;
  logic reset_n;

  env_amp_dsm_if #(.PCM_W(16), .ENV_W(16)) bus ();

  env_amp_dsm #(.PCM_W(16), .ENV_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pcm;
    logic [15:0] env;
    logic [3:0]  vol;
    logic        mute;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [10];
  logic [15:0] sbq [$];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] pcm, input logic [15:0] env,
                                        input logic [3:0] vol, input logic mute);
    longint p;
    longint q;
    p = longint'($signed(pcm)) * longint'({1'b0, env});
    q = (p >>> 16) >>> vol;
    return mute ? 16'h0 : q[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] pcm, input logic [15:0] env, input logic [15:0] exp);
    bus.pcm_in    = pcm;
    bus.env       = env;
    bus.pcm_valid = 1'b1;
    sbq.push_back(exp);
  endtask

  // Scoreboard: every amp_valid pops one expected sample.
  always @(negedge clk) begin
    if (bus.amp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_amp_valid", 32'd1, 32'd0);
      end else begin
        logic [15:0] e;
        e = sbq.pop_front();
        chk("amp_pcm", {16'h0, bus.amp_pcm}, {16'h0, e});
      end
    end
  end

  initial begin
    int ones;
    int runlen;
    logic prev;

    tbl[0] = '{16'h4000, 16'h8000, 4'd0,  1'b0, 16'h2000};
    tbl[1] = '{16'h8000, 16'hFFFF, 4'd0,  1'b0, 16'h8000};
    tbl[2] = '{16'h4000, 16'hFFFF, 4'd2,  1'b0, 16'h0FFF};
    tbl[3] = '{16'h4000, 16'hFFFF, 4'd2,  1'b1, 16'h0000};
    tbl[4] = '{16'hC000, 16'hFFFF, 4'd3,  1'b0, 16'hF800};
    tbl[5] = '{16'h7FFF, 16'h0000, 4'd0,  1'b0, 16'h0000};
    tbl[6] = '{16'hFFFF, 16'h0001, 4'd0,  1'b0, 16'hFFFF};
    tbl[7] = '{16'h7FFF, 16'hFFFF, 4'd15, 1'b0, 16'h0000};
    tbl[8] = '{16'h8000, 16'hFFFF, 4'd15, 1'b0, 16'hFFFF};
    tbl[9] = '{16'hF000, 16'hFFFF, 4'd0,  1'b0, 16'hF000};

    // Reset with random inputs toggling
    reset_n      = 1'b0;
    bus.peak_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.pcm_in    = 16'($urandom);
      bus.env       = 16'($urandom);
      bus.pcm_valid = 1'($urandom);
      bus.vol_shift = 4'($urandom);
      bus.mute      = 1'($urandom);
      tick();
    end
    chk("rst_amp_pcm",   {16'h0, bus.amp_pcm},  32'h0);
    chk("rst_amp_valid", {31'h0, bus.amp_valid}, 32'h0);
    chk("rst_peak_abs",  {16'h0, bus.peak_abs}, 32'h0);
    chk("rst_pdm_out",   {31'h0, bus.pdm_out},  32'h0);
    bus.pcm_valid = 1'b0;
    bus.vol_shift = 4'd0;
    bus.mute      = 1'b0;
    bus.pcm_in    = 16'h0;
    bus.env       = 16'h0;
    tick();
    reset_n = 1'b1;
    tick();

    // DSM at amp_pcm = 0 (mid-scale)
    ones = 0;
    runlen = 0;
    prev = bus.pdm_out;
    for (int i = 0; i < 256; i++) begin
      tick();
      ones += int'(bus.pdm_out);
      if (bus.pdm_out !== prev) runlen++;
      prev = bus.pdm_out;
    end
`ifdef ENV_AMP_DSM_EN
    chk("pdm_ones_mid", ones, 128);
    chk("pdm_toggles_mid", runlen, 256);
`else
    chk("pdm_off_mid", ones, 0);
`endif

    // Latency: valid only in the cycle after E2
    send(16'h4000, 16'h8000, 16'h2000);
    tick();
    bus.pcm_valid = 1'b0;
    chk("lat_e0", {31'h0, bus.amp_valid}, 32'h0);
    tick();
    chk("lat_e1", {31'h0, bus.amp_valid}, 32'h0);
    tick();
    chk("lat_e2_valid", {31'h0, bus.amp_valid}, 32'h1);
    chk("lat_e2_peak",  {16'h0, bus.peak_abs}, 32'h2000);
    tick();
    chk("lat_e3_valid", {31'h0, bus.amp_valid}, 32'h0);
    chk("lat_e3_hold",  {16'h0, bus.amp_pcm},  32'h2000);

    // Most negative result saturates the peak
    send(16'h8000, 16'hFFFF, 16'h8000);
    tick();
    bus.pcm_valid = 1'b0;
    tick();
    tick();
    chk("peak_sat", {16'h0, bus.peak_abs}, 32'h7FFF);

    // Clear alone
    bus.peak_clr = 1'b1;
    tick();
    bus.peak_clr = 1'b0;
    chk("peak_clr", {16'h0, bus.peak_abs}, 32'h0);

    // Volume/mute applied late (after E0) must take effect
    send(16'h4000, 16'hFFFF, 16'h0FFF);
    tick();
    bus.pcm_valid = 1'b0;
    bus.vol_shift = 4'd2;
    tick();
    tick();
    chk("peak_vol2", {16'h0, bus.peak_abs}, 32'h0FFF);
    send(16'h4000, 16'hFFFF, 16'h0000);
    tick();
    bus.pcm_valid = 1'b0;
    bus.mute = 1'b1;
    tick();
    tick();
    chk("peak_mute", {16'h0, bus.peak_abs}, 32'h0FFF);
    bus.mute = 1'b0;
    bus.vol_shift = 4'd0;
    tick();

    // Back-to-back with a clear on the second load edge
    send(16'h1000, 16'hFFFF, 16'h0FFF);
    tick();
    send(16'hF000, 16'hFFFF, 16'hF000);
    tick();
    send(16'h7FFF, 16'hFFFF, 16'h7FFE);
    tick();
    bus.pcm_valid = 1'b0;
    chk("b2b_v1", {31'h0, bus.amp_valid}, 32'h1);
    bus.peak_clr = 1'b1;
    tick();
    bus.peak_clr = 1'b0;
    chk("b2b_v2", {31'h0, bus.amp_valid}, 32'h1);
    chk("b2b_peak_clr", {16'h0, bus.peak_abs}, 32'h1000);
    tick();
    chk("b2b_v3", {31'h0, bus.amp_valid}, 32'h1);
    chk("b2b_peak", {16'h0, bus.peak_abs}, 32'h7FFE);
    tick();
    chk("b2b_end", {31'h0, bus.amp_valid}, 32'h0);

    // Vector table
    foreach (tbl[i]) begin
      bus.vol_shift = tbl[i].vol;
      bus.mute      = tbl[i].mute;
      send(tbl[i].pcm, tbl[i].env, tbl[i].exp);
      tick();
      bus.pcm_valid = 1'b0;
      tick();
      tick();
      tick();
    end

    // Random back-to-back bursts against the model
    for (int b = 0; b < 4; b++) begin
      bus.vol_shift = 4'($urandom_range(0, 15));
      bus.mute      = (b == 3);
      for (int k = 0; k < 5; k++) begin
        logic [15:0] p;
        logic [15:0] e;
        p = 16'($urandom);
        e = 16'($urandom);
        send(p, e, model(p, e, bus.vol_shift, bus.mute));
        tick();
      end
      bus.pcm_valid = 1'b0;
      tick();
      tick();
      tick();
    end
    bus.vol_shift = 4'd0;
    bus.mute      = 1'b0;

    // DSM at amp_pcm = 0xC000 (quarter scale)
    send(16'h8000, 16'h8000, 16'hC000);
    tick();
    bus.pcm_valid = 1'b0;
    tick();
    tick();
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      ones += int'(bus.pdm_out);
    end
`ifdef ENV_AMP_DSM_EN
    chk("pdm_ones_c000", ones, 64);
`else
    chk("pdm_off_c000", ones, 0);
`endif

    // Reset one cycle after E0 drops the in-flight sample
    bus.pcm_in    = 16'h3000;
    bus.env       = 16'hFFFF;
    bus.pcm_valid = 1'b1;
    tick();
    bus.pcm_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      ones += int'(bus.amp_valid);
    end
    chk("midreset_no_valid", ones, 0);
    chk("midreset_amp", {16'h0, bus.amp_pcm}, 32'h0);
    chk("midreset_peak", {16'h0, bus.peak_abs}, 32'h0);

    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
